regfile_write_arbiter: RTL
==========================

Name: regfile_write_arbiter

Overview:
- Owns the single write port of the 32x32 register file in the pipelined MIPS core.
- After reset, a sequencer clears every register to zero, because the register file itself has no reset.
- It then shares the write port among NUM_REQ writeback sources (e.g. ALU, load, mult/div) using round-robin arbitration.
- It drives the register file's wr_index, wr_in and regWrite inputs directly.

Parameters:
- NUM_REQ, 3, number of write requesters.
- ADDR_W, 5, register index width.
- DATA_W, 32, register data width.
- NUM_REGS, 32, registers cleared by the init sequence (index 0 to NUM_REGS-1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester write request; held until granted.
- req_index  input  NUM_REQ*ADDR_W  packed destination indices; requester i uses bits [i*ADDR_W +: ADDR_W].
- req_data  input  NUM_REQ*DATA_W  packed write data; requester i uses bits [i*DATA_W +: DATA_W].
- gnt  output  NUM_REQ  one-hot grant, combinational, same cycle as the winning req.
- wr_index  output  ADDR_W  register file write index, registered.
- wr_in  output  DATA_W  register file write data, registered.
- regWrite  output  1  register file write enable, registered.
- init_done  output  1  high once the clear sequence has completed.
- conflict_cnt  output  8  saturating count of cycles with more than one req active in RUN.

Behaviour:
- FSM states: INIT, RUN.
- Reset (rst=1 at a rising edge):
  - State goes to INIT; init counter = 0; round-robin pointer ptr = 0.
  - regWrite=0, wr_index=0, wr_in=0, init_done=0, conflict_cnt=0.
  - gnt=0 for as long as rst is high.
- INIT:
  - Each edge with rst=0 registers regWrite=1, wr_index=counter, wr_in=0, then increments counter.
  - The edge that issues index NUM_REGS-1 moves to RUN; init_done=1 from that edge.
  - The whole sequence takes NUM_REGS cycles.
  - gnt stays 0 throughout INIT; req is ignored, and requesters keep holding it.
- RUN arbitration:
  - Candidates are searched starting at index ptr, wrapping modulo NUM_REQ.
  - The first active req wins; gnt[winner]=1 combinationally in the same cycle.
- RUN, at the rising edge after a grant:
  - wr_index <= req_index[winner], wr_in <= req_data[winner].
  - regWrite <= 1, unless req_index[winner]==0. A write to $zero is granted and consumed, but regWrite <= 0.
  - ptr <= (winner+1) mod NUM_REQ.
- Write latency: a granted request appears on the register file port one cycle after grant and is written at the following edge.
- RUN, no req active: regWrite <= 0; wr_index and wr_in hold their values; ptr is unchanged.
- Requester protocol:
  - On gnt, the requester either drops req or presents its next write in the following cycle.
  - An ungranted req must keep its index and data stable.
- Fairness: a continuously asserted req is granted within NUM_REQ cycles.
- conflict_cnt: increments at each RUN edge where popcount(req)>1; saturates at 255.
- Reset mid-operation (rst=1 in any state, including mid-INIT):
  - Any pending grant is discarded and regWrite is 0 at the next edge.
  - The clear sequence restarts from index 0.
- init_done never drops except under rst.

Test Plan:
- Reset, then release rst -> regWrite=1 for 32 consecutive cycles with wr_index 0..31 and wr_in=0; init_done=1 after cycle 32; all registers read back 0.
- RUN, req=3'b001, index=3, data=32'hff00ff00 -> gnt=001 same cycle; next cycle wr_index=3, wr_in=32'hff00ff00, regWrite=1; a read of register 3 then returns 32'hff00ff00.
- RUN, req=3'b111 held for 6 cycles with indices 5, 6, 7 -> grant order 001, 010, 100, 001, 010, 100; conflict_cnt=6.
- RUN, req=3'b010, index=0, data=32'hdeadbeef -> gnt=010; next cycle regWrite=0; register 0 still reads 0.
- rst asserted at INIT index 10 with req=3'b100 held -> gnt stays 0; the sequence restarts at index 0; the first grant to requester 2 arrives after the 32-cycle clear.
- Held req during 300 conflict cycles -> conflict_cnt saturates at 255 and never wraps.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Write-port owner for the 32x32 MIPS register file.
// After reset it writes zero to every register, then arbitrates the single
// write port among NUM_REQ writeback sources in round-robin order.
module regfile_write_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_index,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]         wr_index,
    output logic [DATA_W-1:0]         wr_in,
    output logic                      regWrite,
    output logic                      init_done,
    output logic [7:0]                conflict_cnt
);

    localparam int          PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned NUM_REQ_U = NUM_REQ;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [ADDR_W-1:0]  init_cnt;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   ptr_next;
    logic [PTR_W-1:0]   cand;
    logic [PTR_W-1:0]   win;
    logic               win_vld;
    logic [ADDR_W-1:0]  win_index;
    logic [DATA_W-1:0]  win_data;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= INIT;
        else     state <= state_next;
    end

    // Next state: leave INIT on the edge that issues the last clear write
    always_comb begin
        state_next = state;
        if (state == INIT && init_cnt == ADDR_W'(NUM_REGS - 1))
            state_next = RUN;
    end

    // Round-robin search from ptr; grant suppressed under reset and in INIT
    always_comb begin
        gnt       = '0;
        cand      = '0;
        win       = '0;
        win_vld   = 1'b0;
        win_index = '0;
        win_data  = '0;
        ptr_next  = '0;
        if (!rst && state == RUN) begin
            for (int unsigned k = 0; k < NUM_REQ_U; k++) begin
                cand = PTR_W'((32'(ptr) + k) % NUM_REQ_U);
                if (!win_vld && req[cand]) begin
                    win_vld = 1'b1;
                    win     = cand;
                end
            end
        end
        if (win_vld) begin
            gnt[win]  = 1'b1;
            win_index = req_index[win*ADDR_W +: ADDR_W];
            win_data  = req_data[win*DATA_W +: DATA_W];
        end
        ptr_next = (32'(win) == NUM_REQ_U - 1) ? '0 : win + 1'b1;
    end

    // Clear sequencer, write-port registers and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            init_cnt <= '0;
            ptr      <= '0;
            regWrite <= 1'b0;
            wr_index <= '0;
            wr_in    <= '0;
        end else if (state == INIT) begin
            regWrite <= 1'b1;
            wr_index <= init_cnt;
            wr_in    <= '0;
            init_cnt <= init_cnt + 1'b1;
        end else if (win_vld) begin
            // $zero writes are consumed but never reach the register file
            regWrite <= (win_index != '0);
            wr_index <= win_index;
            wr_in    <= win_data;
            ptr      <= ptr_next;
        end else begin
            regWrite <= 1'b0;
        end
    end

    // Saturating count of RUN cycles with competing requests
    always_ff @(posedge clk) begin
        if (rst)
            conflict_cnt <= '0;
        else if (state == RUN && $countones(req) > 1 && conflict_cnt != 8'hFF)
            conflict_cnt <= conflict_cnt + 8'd1;
    end

    assign init_done = (state == RUN);

endmodule
